z_reg: RTL and testbench
========================

Z_REG -- requirements
Module: z_reg

Interface
REQ-001 Parameter WIDTH, default 12, data-path width of dataIn; SHALL be legal for any value >= 1.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rstN  input  1  reset, asynchronous, active-low.
REQ-004 wrEn  input  1  write enable; when high, the zero flag SHALL be updated at the next rising clk edge.
REQ-005 dataIn  input  WIDTH  value to be tested for zero.
REQ-006 Zout  output  1  registered zero flag; 1 means the last written dataIn was all-zero.
REQ-007 The block SHALL have exactly one clock domain (clk) and one reset (rstN); no other ports.

Function
REQ-008 At a rising clk edge with rstN=1 and wrEn=1, Zout SHALL load 1 if every bit of dataIn is 0, else 0.
REQ-009 At a rising clk edge with rstN=1 and wrEn=0, Zout SHALL hold its previous value regardless of dataIn.
REQ-010 Latency: Zout SHALL reflect the dataIn sampled at edge N immediately after edge N (one-cycle write latency); no combinational path from dataIn or wrEn to Zout.
REQ-011 Zero test SHALL cover all WIDTH bits; any single set bit (including bit 0 and bit WIDTH-1) SHALL yield Zout=0.
REQ-012 Consecutive writes SHALL each take effect on their own edge; back-to-back zero/non-zero values SHALL toggle Zout every cycle.
REQ-013 dataIn is not stored; only the 1-bit flag is state.
REQ-014 With WIDTH=1, Zout SHALL equal the inverse of the written bit.

Reset
REQ-015 While rstN=0, Zout SHALL be 0, asserted asynchronously without waiting for a clk edge.
REQ-016 Reset SHALL take priority over wrEn; a write coinciding with rstN=0 SHALL be discarded.
REQ-017 After rstN deasserts, Zout SHALL stay 0 until the first rising edge with wrEn=1.
REQ-018 Reset asserted mid-operation (after any sequence of writes) SHALL clear Zout identically to power-up reset.

Structure
REQ-019 Shared package SHALL hold the reset value constant (ZFLAG_RST_VAL = 1'b0) and the default width constant (12).
REQ-020 Zero detection SHALL be a separate combinational sub-module zero_detect (parameter WIDTH, input WIDTH-bit vector, output 1-bit is_zero), implemented as a balanced reduction-OR tree with final inversion, generate-based so depth is ceil(log2(WIDTH)).
REQ-021 z_reg SHALL instantiate zero_detect once and contain a single flip-flop with async active-low clear and enable.
REQ-022 Design SHALL include embedded assertions: Zout known after reset release; Zout==0 whenever rstN==0; Zout unchanged across an edge with wrEn=0; Zout after a write equals (past dataIn == 0).

Verification (WIDTH=12 unless stated)
REQ-023 Hold rstN=0 for one cycle, then rstN=1, wrEn=0, dataIn=0 -> Zout=0 throughout and after the edge (no write).
REQ-024 wrEn=1, dataIn=12'h000 -> Zout=1 after next edge; then wrEn=1, dataIn=12'h004 -> Zout=0 after following edge.
REQ-025 Walking-one: write 12'h001, 12'h800, then 12'h000 -> Zout sequence 0, 0, 1; then wrEn=0 with dataIn=12'hFFF for 3 cycles -> Zout stays 1.
REQ-026 With Zout=1, drive rstN=0 between clock edges -> Zout falls to 0 before the next edge; wrEn=1, dataIn=0 during reset -> Zout remains 0.
REQ-027 10+ cycles of random dataIn, wrEn, rstN -> every cycle Zout matches a reference model (reset clear, write = (dataIn==0), else hold), no assertion failures.
REQ-028 Re-run REQ-024 with WIDTH=1 (write 0 -> Zout=1, write 1 -> Zout=0) and WIDTH=33 (write only bit 32 set -> Zout=0).

Source files
------------

// File: rtl/z_reg_pkg.sv
// Shared constants and defaults for the zero-flag register.
package z_reg_pkg;

   // Default data-path width of the tested value.
   localparam int unsigned ZREG_WIDTH_DEF = 12;

   // Value the zero flag takes while reset is asserted.
   localparam logic ZFLAG_RST_VAL = 1'b0;

endpackage : z_reg_pkg

// File: rtl/z_reg_if.sv
// Write-side bundle for z_reg: write enable, tested value and returned flag.
interface z_reg_if
   import z_reg_pkg::*;
#(
   parameter int unsigned WIDTH = ZREG_WIDTH_DEF
);

   logic             wr_en;
   logic [WIDTH-1:0] data_in;
   logic             zout;

   // Requester drives the write and observes the flag.
   modport master (output wr_en, output data_in, input zout);

   // Flag register consumes the write and returns the flag.
   modport slave (input wr_en, input data_in, output zout);

endinterface : z_reg_if

// File: rtl/z_reg_zero_detect.sv
// Combinational all-zero detector built as a balanced OR tree with a final inversion.
module zero_detect
   import z_reg_pkg::*;
#(
   parameter int unsigned WIDTH = ZREG_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] vec,
   output logic             is_zero
);

   // Tree depth is ceil(log2(WIDTH)); leaves are padded with zeros to a power of two.
   localparam int unsigned LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
   localparam int unsigned LEAVES = 1 << LEVELS;

   logic [LEAVES-1:0] leaf;

   // Map input bits onto leaves; padding leaves are neutral for OR.
   for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
      if (k < WIDTH) begin : g_bit
         assign leaf[k] = vec[k];
      end else begin : g_pad
         assign leaf[k] = 1'b0;
      end
   end

   // Each level halves the node count by OR-ing adjacent pairs of the level below.
   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      localparam int unsigned NODES = LEAVES >> l;
      logic [NODES-1:0] node;
      if (l == 0) begin : g_base
         assign node = leaf;
      end else begin : g_reduce
         for (genvar n = 0; n < NODES; n++) begin : g_node
            assign node[n] = g_lvl[l-1].node[2*n] | g_lvl[l-1].node[2*n+1];
         end
      end
   end

   // Root holds "any bit set"; invert for the zero indication.
   assign is_zero = ~g_lvl[LEVELS].node[0];

endmodule : zero_detect

// File: rtl/z_reg.sv
// Registered zero flag: on a write, remembers whether the written value was all-zero.
module z_reg
   import z_reg_pkg::*;
#(
   parameter int unsigned WIDTH = ZREG_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             wrEn,
   input  logic [WIDTH-1:0] dataIn,
   output logic             Zout
);

   logic is_zero;
   logic zout_d;
   logic zout_q;

   zero_detect #(
      .WIDTH (WIDTH)
   ) u_zero_detect (
      .vec     (dataIn),
      .is_zero (is_zero)
   );

   // Load the detector result on a write, otherwise hold the flag.
   always_comb begin
      zout_d = zout_q;
      if (wrEn) begin
         zout_d = is_zero;
      end
   end

   // Single enabled flag flop with asynchronous clear.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         zout_q <= ZFLAG_RST_VAL;
      end else begin
         zout_q <= zout_d;
      end
   end

   assign Zout = zout_q;

   // Flag must never be X/Z once out of reset.
   a_known : assert property (@(posedge clk) rstN |-> !$isunknown(zout_q));

   // Flag is cleared whenever reset is held.
   a_rst_clear : assert property (@(posedge clk) !rstN |-> (zout_q == ZFLAG_RST_VAL));

   // Without a write the flag is unchanged across the edge.
   a_hold : assert property (@(posedge clk) disable iff (!rstN)
                             !wrEn |=> $stable(zout_q));

   // After a write the flag equals the zero test of the sampled value.
   a_write : assert property (@(posedge clk) disable iff (!rstN)
                              wrEn |=> (zout_q == ($past(dataIn) == '0)));

endmodule : z_reg

// File: tb/tb_z_reg.sv
// Directed and randomized checks of z_reg at widths 12, 1 and 33.
module tb_z_reg;
   import z_reg_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   z_reg_if #(.WIDTH(12)) bus12 ();
   z_reg_if #(.WIDTH(1))  bus1  ();
   z_reg_if #(.WIDTH(33)) bus33 ();

   z_reg #(.WIDTH(12)) dut12 (
      .clk    (clk),
      .rstN   (rst_n),
      .wrEn   (bus12.wr_en),
      .dataIn (bus12.data_in),
      .Zout   (bus12.zout)
   );

   z_reg #(.WIDTH(1)) dut1 (
      .clk    (clk),
      .rstN   (rst_n),
      .wrEn   (bus1.wr_en),
      .dataIn (bus1.data_in),
      .Zout   (bus1.zout)
   );

   z_reg #(.WIDTH(33)) dut33 (
      .clk    (clk),
      .rstN   (rst_n),
      .wrEn   (bus33.wr_en),
      .dataIn (bus33.data_in),
      .Zout   (bus33.zout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        wr;
      logic [11:0] d;
      logic        exp;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic m12, m1, m33;
      logic        r_rst, r_wr12, r_wr1, r_wr33;
      logic [11:0] r_d12;
      logic [0:0]  r_d1;
      logic [32:0] r_d33;

      checks   = 0;
      failures = 0;

      tbl[0]  = '{1'b0, 1'b0, 12'h000, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 12'h000, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 12'h000, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 12'h004, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 12'h001, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 12'h800, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 12'h000, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 12'hFFF, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 12'hFFF, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 12'hFFF, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 12'hFFF, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 12'h000, 1'b1};
      tbl[12] = '{1'b1, 1'b1, 12'h010, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 12'h000, 1'b1};
      tbl[14] = '{1'b0, 1'b1, 12'h000, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 12'h000, 1'b0};
      tbl[16] = '{1'b1, 1'b0, 12'h000, 1'b0};
      tbl[17] = '{1'b1, 1'b1, 12'h000, 1'b1};

      rst_n         = 1'b0;
      bus12.wr_en   = 1'b0;
      bus12.data_in = '0;
      bus1.wr_en    = 1'b0;
      bus1.data_in  = '0;
      bus33.wr_en   = 1'b0;
      bus33.data_in = '0;
      #1;
      chk("reset_initial", bus12.zout, 1'b0);

      // Table-driven vectors on the 12-bit instance.
      for (int i = 0; i < 18; i++) begin
         rst_n         = tbl[i].rst_n;
         bus12.wr_en   = tbl[i].wr;
         bus12.data_in = tbl[i].d;
         step();
         chk($sformatf("vec%0d", i), bus12.zout, tbl[i].exp);
      end

      // Asynchronous reset between edges clears a set flag before the next edge.
      @(negedge clk);
      rst_n         = 1'b0;
      bus12.wr_en   = 1'b1;
      bus12.data_in = 12'h000;
      #1;
      chk("async_rst_midcycle", bus12.zout, 1'b0);
      step();
      chk("write_during_rst", bus12.zout, 1'b0);
      rst_n       = 1'b1;
      bus12.wr_en = 1'b0;
      step();
      chk("no_write_after_rst", bus12.zout, 1'b0);

      // Narrow and wide instances.
      bus1.wr_en    = 1'b1;
      bus1.data_in  = 1'b0;
      bus33.wr_en   = 1'b1;
      bus33.data_in = 33'h0_0000_0000;
      step();
      chk("w1_write0", bus1.zout, 1'b1);
      chk("w33_write0", bus33.zout, 1'b1);
      bus1.data_in  = 1'b1;
      bus33.data_in = 33'h1_0000_0000;
      step();
      chk("w1_write1", bus1.zout, 1'b0);
      chk("w33_bit32", bus33.zout, 1'b0);
      bus33.data_in = 33'h0_0000_0000;
      step();
      chk("w33_zero_again", bus33.zout, 1'b1);
      bus33.data_in = 33'h0_0000_0001;
      step();
      chk("w33_bit0", bus33.zout, 1'b0);

      // Randomized stimulus against a reference model of all three widths.
      m12 = bus12.zout;
      m1  = bus1.zout;
      m33 = bus33.zout;
      for (int c = 0; c < 40; c++) begin
         r_rst  = ($urandom_range(0, 7) != 0);
         r_wr12 = 1'($urandom);
         r_wr1  = 1'($urandom);
         r_wr33 = 1'($urandom);
         r_d12  = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom);
         r_d1   = 1'($urandom);
         r_d33  = ($urandom_range(0, 2) == 0) ? 33'h0 : 33'({$urandom, $urandom});
         rst_n         = r_rst;
         bus12.wr_en   = r_wr12;
         bus12.data_in = r_d12;
         bus1.wr_en    = r_wr1;
         bus1.data_in  = r_d1;
         bus33.wr_en   = r_wr33;
         bus33.data_in = r_d33;
         if (!r_rst) begin
            m12 = 1'b0;
            m1  = 1'b0;
            m33 = 1'b0;
         end else begin
            if (r_wr12) m12 = (r_d12 == 12'h000);
            if (r_wr1)  m1  = (r_d1 == 1'b0);
            if (r_wr33) m33 = (r_d33 == 33'h0);
         end
         step();
         chk($sformatf("rand12_c%0d", c), bus12.zout, m12);
         chk($sformatf("rand1_c%0d", c), bus1.zout, m1);
         chk($sformatf("rand33_c%0d", c), bus33.zout, m33);
      end

      // Mid-operation reset clears every instance like power-up reset.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midop_rst_w12", bus12.zout, 1'b0);
      chk("midop_rst_w1", bus1.zout, 1'b0);
      chk("midop_rst_w33", bus33.zout, 1'b0);
      step();
      rst_n = 1'b1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_z_reg
